// File: rtl/umul_pkg.sv
// Shared definitions for the approximate unsigned multiplier family: mode encoding and a
// reference approximate-product function usable by datapath and scoreboard alike.
package umul_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // Truncated/compensated product for any legal w (<= 32) and l (< w); operands zero-extended.
    function automatic logic [63:0] approx_prod(int unsigned w, int unsigned l,
                                                logic [31:0] x, logic [31:0] y);
        logic [63:0] acc;
        logic [63:0] row;
        logic [63:0] mask;
        logic        b;
        acc = '0;
        b   = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            row = x[i] ? ({32'b0, y} << i) : 64'b0;
            if (i >= l && i < w) begin
                acc = acc + row;
            end else if (i < l) begin
                b   = b | row[w-1];
                acc = acc + ((row >> w) << w);
            end
        end
        acc  = acc + ({63'b0, b} << w);
        mask = (w >= 32) ? '1 : (64'd1 << (2 * w)) - 64'd1;
        return acc & mask;
    endfunction

endpackage

// File: rtl/approx_umul_pipe_if.sv
// Operand/result stream bundle for approx_umul_pipe: valid/ready on both sides plus tag/mode.
interface approx_umul_pipe_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic             mode;
    logic [TAG_W-1:0] tag;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   z;
    logic [TAG_W-1:0] out_tag;
    logic             out_mode;

    modport master (
        output in_valid, x, y, mode, tag, out_ready,
        input  in_ready, out_valid, z, out_tag, out_mode
    );

    modport slave (
        input  in_valid, x, y, mode, tag, out_ready,
        output in_ready, out_valid, z, out_tag, out_mode
    );
endinterface

// File: rtl/approx_umul_core.sv
// Combinational datapath: returns a product term and a compensation term whose sum is the
// exact (mode=0) or truncated/compensated (mode=1) product. The final add is left to the caller.
module approx_umul_core
    import umul_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned L = 2
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic           mode,
    output logic [2*W-1:0] prod,
    output logic [2*W-1:0] comp
);

    logic [2*W-1:0] y_ext;
    logic [2*W-1:0] x_ext;
    logic [2*W-1:0] x_hi_ext;
    logic [2*W-1:0] row;
    logic [2*W-1:0] col_sum;
    logic           col_or;

    assign y_ext    = {{W{1'b0}}, y};
    assign x_ext    = {{W{1'b0}}, x};
    assign x_hi_ext = {{W{1'b0}}, {L{1'b0}}, x[W-1:L]};

    // Dropped rows: column W-1 is OR-reduced (not summed), columns >= W are summed exactly.
    always_comb begin
        row     = '0;
        col_sum = '0;
        col_or  = 1'b0;
        for (int i = 0; i < int'(L); i++) begin
            row     = x[i] ? (y_ext << i) : '0;
            col_or  = col_or | row[W-1];
            col_sum = col_sum + {row[2*W-1:W], {W{1'b0}}};
        end
    end

    always_comb begin
        prod = x_ext * y_ext;
        comp = '0;
        if (mode == MODE_APPROX) begin
            prod = (y_ext * x_hi_ext) << L;
            comp = col_sum + {{(W-1){1'b0}}, col_or, {W{1'b0}}};
        end
    end

endmodule

// File: rtl/approx_umul_pipe.sv
// Elastic STAGES-deep pipeline around approx_umul_core with per-stage valid bits, tag/mode
// pass-through and a saturating counter of accepted approximate transactions.
module approx_umul_pipe
    import umul_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned L      = 2,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    approx_umul_pipe_if.slave bus,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  approx_cnt
);

    if (W < 4 || W > 32) begin : g_chk_w
        $error("approx_umul_pipe: W must be in 4..32");
    end
    if (L < 1 || L > W - 1) begin : g_chk_l
        $error("approx_umul_pipe: L must be in 1..W-1");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_chk_stages
        $error("approx_umul_pipe: STAGES must be in 1..4");
    end
    if (TAG_W < 1 || CNT_W < 1) begin : g_chk_widths
        $error("approx_umul_pipe: TAG_W and CNT_W must be at least 1");
    end

    logic                init_q;
    logic                in_ready;
    logic [2*W-1:0]      core_prod;
    logic [2*W-1:0]      core_comp;
    logic [STAGES-1:0]   v_q;
    logic [STAGES-1:0]   rdy;
    logic [STAGES-1:0]   up;
    logic [STAGES-1:0]   load;
    logic [STAGES-1:0]   mode_q;
    logic [TAG_W-1:0]    tag_q [STAGES];
    logic [2*W-1:0]      z_q;
    logic [CNT_W-1:0]    cnt_q;

    approx_umul_core #(
        .W(W),
        .L(L)
    ) u_core (
        .x   (bus.x),
        .y   (bus.y),
        .mode(bus.mode),
        .prod(core_prod),
        .comp(core_comp)
    );

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) init_q <= 1'b0;
        else        init_q <= 1'b1;
    end

    // Stage k can take new data unless it and every stage downstream are full and stalled.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        rdy      = '0;
        up       = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            all_full = all_full & v_q[k];
            rdy[k]   = !all_full || bus.out_ready;
        end
        up[0] = bus.in_valid && init_q;
        for (int k = 1; k < int'(STAGES); k++) begin
            up[k] = v_q[k-1];
        end
        load = up & rdy;
    end

    assign in_ready = init_q && rdy[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            mode_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) tag_q[k] <= '0;
        end else begin
            v_q <= (v_q & ~rdy) | (up & rdy);
            if (load[0]) begin
                tag_q[0]  <= bus.tag;
                mode_q[0] <= bus.mode;
            end
            for (int k = 1; k < int'(STAGES); k++) begin
                if (load[k]) begin
                    tag_q[k]  <= tag_q[k-1];
                    mode_q[k] <= mode_q[k-1];
                end
            end
        end
    end

    // Partial product and compensation enter stage 0; their sum lands in the last stage.
    if (STAGES == 1) begin : g_single
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       z_q <= '0;
            else if (load[0]) z_q <= core_prod + core_comp;
        end
    end else begin : g_multi
        logic [2*W-1:0] prod_q [STAGES-1];
        logic [2*W-1:0] comp_q [STAGES-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < int'(STAGES) - 1; k++) begin
                    prod_q[k] <= '0;
                    comp_q[k] <= '0;
                end
            end else begin
                if (load[0]) begin
                    prod_q[0] <= core_prod;
                    comp_q[0] <= core_comp;
                end
                for (int k = 1; k < int'(STAGES) - 1; k++) begin
                    if (load[k]) begin
                        prod_q[k] <= prod_q[k-1];
                        comp_q[k] <= comp_q[k-1];
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)              z_q <= '0;
            else if (load[STAGES-1]) z_q <= prod_q[STAGES-2] + comp_q[STAGES-2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (bus.in_valid && in_ready && bus.mode == MODE_APPROX && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.z         = z_q;
    assign bus.out_tag   = tag_q[STAGES-1];
    assign bus.out_mode  = mode_q[STAGES-1];
    assign approx_cnt    = cnt_q;

endmodule

// File: tb/tb_approx_umul_pipe.sv
// Randomised and directed bench for approx_umul_pipe against an arithmetic reference model.
module tb_approx_umul_pipe;
    import umul_pkg::*;

    localparam int unsigned TW   = 8;
    localparam int unsigned TL   = 2;
    localparam int unsigned TS   = 2;
    localparam int unsigned TTAG = 4;
    localparam int          NTX  = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cnt_clr;
    logic        cnt_clr_c;
    logic [15:0] approx_cnt;
    logic [3:0]  approx_cnt_c;

    approx_umul_pipe_if #(.W(TW), .TAG_W(TTAG)) bus ();
    approx_umul_pipe_if #(.W(TW), .TAG_W(TTAG)) bus_c ();

    approx_umul_pipe #(.W(TW), .L(TL), .STAGES(TS), .TAG_W(TTAG), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cnt_clr   (cnt_clr),
        .approx_cnt(approx_cnt)
    );

    approx_umul_pipe #(.W(TW), .L(TL), .STAGES(3), .TAG_W(TTAG), .CNT_W(4)) dut_c (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_c),
        .cnt_clr   (cnt_clr_c),
        .approx_cnt(approx_cnt_c)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Product from the arithmetic rules: high rows times y, plus OR'd column W-1, plus
    // exact sum of dropped-row bits at weight 2^W and above.
    function automatic logic [15:0] model(logic [7:0] x, logic [7:0] y, logic m);
        int unsigned xi, yi, hi, s, row;
        bit          b;
        xi = x;
        yi = y;
        if (m == MODE_EXACT) return 16'(xi * yi);
        hi = ((xi >> TL) * yi) << TL;
        s  = 0;
        b  = 1'b0;
        for (int i = 0; i < int'(TL); i++) begin
            row = x[i] ? (yi << i) : 0;
            b   = b | row[TW-1];
            s   = s + ((row >> TW) << TW);
        end
        return 16'(hi + s + (b ? (1 << TW) : 0));
    endfunction

    task automatic directed(input string name, input logic [7:0] x, input logic [7:0] y,
                            input logic m, input logic [3:0] tg, input logic [15:0] exp_z);
        int lat;
        @(negedge clk);
        bus.x = x; bus.y = y; bus.mode = m; bus.tag = tg;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #4;
        check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (m == MODE_APPROX) exp_cnt++;
        lat = 0;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(TS - 1));
        check({name, "_z"}, 64'(bus.z), 64'(exp_z));
        check({name, "_tag"}, 64'(bus.out_tag), 64'(tg));
        check({name, "_mode"}, 64'(bus.out_mode), 64'(m));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] q_z [$];
        logic [3:0]  q_t [$];
        logic        q_m [$];
        logic [7:0]  cx, cy;
        logic        cm;
        logic [3:0]  ct;
        logic [15:0] hz;
        logic [3:0]  ht;
        logic        hm;
        bit          have, stall;
        int          sent, recv, cyc, acc, seen;

        bus.in_valid = 0; bus.x = 0; bus.y = 0; bus.mode = 0; bus.tag = 0; bus.out_ready = 0;
        bus_c.in_valid = 0; bus_c.x = 0; bus_c.y = 0; bus_c.mode = 0; bus_c.tag = 0;
        bus_c.out_ready = 0;
        cnt_clr = 0; cnt_clr_c = 0;

        #22;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_z", 64'(bus.z), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_out_mode", 64'(bus.out_mode), 64'd0);
        check("rst_cnt", 64'(approx_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        check("pkg_approx_prod", umul_pkg::approx_prod(8, 2, 32'hFF, 32'hFF), 64'hFD04);

        directed("ff_ff_approx", 8'hFF, 8'hFF, 1'b1, 4'h1, 16'hFD04);
        directed("ff_ff_exact",  8'hFF, 8'hFF, 1'b0, 4'h2, 16'hFE01);
        directed("03_80_approx", 8'h03, 8'h80, 1'b1, 4'h3, 16'h0200);
        directed("04_05_approx", 8'h04, 8'h05, 1'b1, 4'h4, 16'h0014);
        directed("04_05_exact",  8'h04, 8'h05, 1'b0, 4'h5, 16'h0014);
        check("cnt_after_directed", 64'(approx_cnt), 64'(exp_cnt));

        // Fill with the output stalled, then drain.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.mode      = MODE_EXACT;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            bus.tag = 4'(acc);
            bus.x   = 8'($urandom);
            bus.y   = 8'($urandom);
            #4;
            if (bus.in_ready) begin
                q_z.push_back(model(bus.x, bus.y, MODE_EXACT));
                acc++;
            end
            @(negedge clk);
        end
        check("fill_accepts", 64'(acc), 64'(TS));
        check("fill_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < int'(TS); i++) begin
            #4;
            check("drain_valid", 64'(bus.out_valid), 64'd1);
            check("drain_tag", 64'(bus.out_tag), 64'(i));
            check("drain_z", 64'(bus.z), 64'(q_z.pop_front()));
            @(negedge clk);
        end
        #4;
        check("drain_empty", 64'(bus.out_valid), 64'd0);
        q_z.delete();

        // Random streaming with 50% output backpressure.
        sent = 0; recv = 0; cyc = 0; have = 0; stall = 0;
        cx = 0; cy = 0; cm = 0; ct = 0; hz = 0; ht = 0; hm = 0;
        while ((sent < NTX || recv < NTX) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!have && sent < NTX) begin
                cx = 8'($urandom); cy = 8'($urandom);
                cm = 1'($urandom); ct = 4'($urandom);
                have = 1;
            end
            bus.in_valid = have;
            bus.x = cx; bus.y = cy; bus.mode = cm; bus.tag = ct;
            bus.out_ready = 1'($urandom_range(0, 1));
            #4;
            if (stall) begin
                check("stall_valid", 64'(bus.out_valid), 64'd1);
                check("stall_z", 64'(bus.z), 64'(hz));
                check("stall_tag", 64'(bus.out_tag), 64'(ht));
                check("stall_mode", 64'(bus.out_mode), 64'(hm));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q_z.size() == 0) begin
                    check("stream_spurious", 64'd1, 64'd0);
                end else begin
                    check("stream_z", 64'(bus.z), 64'(q_z.pop_front()));
                    check("stream_tag", 64'(bus.out_tag), 64'(q_t.pop_front()));
                    check("stream_mode", 64'(bus.out_mode), 64'(q_m.pop_front()));
                end
                recv++;
            end
            stall = bus.out_valid && !bus.out_ready;
            hz = bus.z; ht = bus.out_tag; hm = bus.out_mode;
            if (bus.in_valid && bus.in_ready) begin
                q_z.push_back(model(cx, cy, cm));
                q_t.push_back(ct);
                q_m.push_back(cm);
                if (cm == MODE_APPROX) exp_cnt++;
                sent++;
                have = 0;
            end
        end
        bus.in_valid = 1'b0;
        check("stream_received", 64'(recv), 64'(NTX));
        check("stream_leftover", 64'(q_z.size()), 64'd0);
        check("stream_cnt", 64'(approx_cnt), 64'(exp_cnt));

        // Reset with two approximate transactions in flight.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.mode      = MODE_APPROX;
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_cnt", 64'(approx_cnt), 64'd0);
        check("midrst_z", 64'(bus.z), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("midrst_no_stale", 64'(seen), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);

        // Saturation and clear on the CNT_W=4, STAGES=3 instance.
        check("c_rst_cnt", 64'(approx_cnt_c), 64'd0);
        @(negedge clk);
        bus_c.out_ready = 1'b1;
        bus_c.in_valid  = 1'b1;
        bus_c.mode      = MODE_APPROX;
        acc = 0;
        cyc = 0;
        while (acc < 17 && cyc < 60) begin
            #4;
            if (bus_c.in_ready) acc++;
            @(negedge clk);
            cyc++;
        end
        bus_c.in_valid = 1'b0;
        check("c_accepts", 64'(acc), 64'd17);
        check("c_saturated", 64'(approx_cnt_c), 64'd15);
        @(negedge clk);
        bus_c.in_valid = 1'b1;
        cnt_clr_c = 1'b1;
        #4;
        check("c_clr_in_ready", 64'(bus_c.in_ready), 64'd1);
        @(posedge clk);
        #1;
        check("c_clr_priority", 64'(approx_cnt_c), 64'd0);
        cnt_clr_c = 1'b0;
        @(posedge clk);
        #1;
        bus_c.in_valid = 1'b0;
        check("c_count_after_clr", 64'(approx_cnt_c), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
